io_bus_sequencer: RTL and testbench

//  Sequences a complete external IO transfer through the io port block. The CPU control unit

---
 rtl/io_bus_sequencer_if.sv | 31 +++
 rtl/io_bus_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_io_bus_sequencer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_bus_sequencer_if.sv
// Handshake and bus bundle between the CPU control unit, io_bus_sequencer and the io port block.
// The sequencer uses the slave modport; the control/io side uses master.
interface io_bus_sequencer_if;
    logic       start;
    logic       rd_wr;
    logic [7:0] port_addr;
    logic [7:0] wdata;
    logic       ack;
    logic [7:0] bus_in;
    logic [7:0] bus_out;
    logic       io_input_output;
    logic       io_data_address;
    logic       io_clk_e;
    logic       io_clk_s;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       timeout_err;

    modport master (
        output start, rd_wr, port_addr, wdata, ack, bus_in,
        input  bus_out, io_input_output, io_data_address, io_clk_e, io_clk_s,
        input  busy, done, rdata, timeout_err
    );

    modport slave (
        input  start, rd_wr, port_addr, wdata, ack, bus_in,
        output bus_out, io_input_output, io_data_address, io_clk_e, io_clk_s,
        output busy, done, rdata, timeout_err
    );
endinterface

// File: rtl/io_bus_sequencer.sv
// Runs one address phase and one data phase on the io block per accepted request.
// Optional data-strobe timeout is built when IO_SEQ_TIMEOUT_EN is defined.
module io_bus_sequencer #(
    parameter int unsigned SETUP_CYC   = 1,
    parameter int unsigned STROBE_CYC  = 2,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input logic              clk,
    input logic              reset_n,
    io_bus_sequencer_if.slave bus
);

    if (SETUP_CYC < 1 || SETUP_CYC > 15) begin : g_bad_setup
        $error("SETUP_CYC out of range 1..15");
    end
    if (STROBE_CYC < 1 || STROBE_CYC > 15) begin : g_bad_strobe
        $error("STROBE_CYC out of range 1..15");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYC out of range 1..255");
    end

    localparam logic [3:0] SetupLast  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] StrobeLast = 4'(STROBE_CYC - 1);

    typedef enum logic [2:0] {StIdle, StASetup, StAStrobe, StDSetup, StDStrobe, StDone} state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       rd_wr_q, rd_wr_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic [7:0] bus_out_q, bus_out_d;
    logic       io_io_q, io_io_d;
    logic       io_da_q, io_da_d;
    logic       clk_e_q, clk_e_d;
    logic       clk_s_q, clk_s_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
`ifdef IO_SEQ_TIMEOUT_EN
    localparam logic [7:0] TmoLast = 8'(TIMEOUT_CYC - 1);
    logic [7:0] tmo_q, tmo_d;
    logic       terr_q, terr_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_wr_d = rd_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef IO_SEQ_TIMEOUT_EN
        tmo_d   = tmo_q;
        terr_d  = terr_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StASetup;
                    cnt_d   = 4'd0;
                    rd_wr_d = bus.rd_wr;
                    addr_d  = bus.port_addr;
                    wdata_d = bus.wdata;
`ifdef IO_SEQ_TIMEOUT_EN
                    terr_d  = 1'b0;
`endif
                end
            end
            StASetup: begin
                if (cnt_q == SetupLast) begin
                    state_d = StAStrobe;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StAStrobe: begin
                if (cnt_q == StrobeLast) begin
                    state_d = StDSetup;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StDSetup: begin
                if (cnt_q == SetupLast) begin
                    state_d = StDStrobe;
                    cnt_d   = 4'd0;
`ifdef IO_SEQ_TIMEOUT_EN
                    tmo_d   = 8'd0;
`endif
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StDStrobe: begin
`ifdef IO_SEQ_TIMEOUT_EN
                tmo_d = tmo_q + 8'd1;
`endif
                // cnt saturates at StrobeLast, so it doubles as "minimum strobe time met"
                if (cnt_q == StrobeLast && bus.ack) begin
                    state_d = StDone;
                    if (!rd_wr_q) rdata_d = bus.bus_in;
`ifdef IO_SEQ_TIMEOUT_EN
                end else if (tmo_q == TmoLast) begin
                    state_d = StDone;
                    terr_d  = 1'b1;
`endif
                end else if (cnt_q != StrobeLast) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
            default: state_d = StIdle;
        endcase

        // Outputs are decoded from the next state so they appear registered, in step with it
        bus_out_d = 8'd0;
        io_io_d   = 1'b0;
        io_da_d   = 1'b0;
        clk_e_d   = 1'b0;
        clk_s_d   = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        unique case (state_d)
            StASetup, StAStrobe: begin
                bus_out_d = addr_d;
                io_io_d   = 1'b1;
                io_da_d   = 1'b1;
                busy_d    = 1'b1;
                clk_s_d   = (state_d == StAStrobe);
            end
            StDSetup, StDStrobe: begin
                bus_out_d = rd_wr_d ? wdata_d : 8'd0;
                io_io_d   = rd_wr_d;
                busy_d    = 1'b1;
                clk_s_d   = (state_d == StDStrobe) && rd_wr_d;
                clk_e_d   = (state_d == StDStrobe) && !rd_wr_d;
            end
            StDone:  done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            rd_wr_q   <= 1'b0;
            addr_q    <= 8'd0;
            wdata_q   <= 8'd0;
            rdata_q   <= 8'd0;
            bus_out_q <= 8'd0;
            io_io_q   <= 1'b0;
            io_da_q   <= 1'b0;
            clk_e_q   <= 1'b0;
            clk_s_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef IO_SEQ_TIMEOUT_EN
            tmo_q     <= 8'd0;
            terr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_wr_q   <= rd_wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            bus_out_q <= bus_out_d;
            io_io_q   <= io_io_d;
            io_da_q   <= io_da_d;
            clk_e_q   <= clk_e_d;
            clk_s_q   <= clk_s_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef IO_SEQ_TIMEOUT_EN
            tmo_q     <= tmo_d;
            terr_q    <= terr_d;
`endif
        end
    end

    assign bus.bus_out         = bus_out_q;
    assign bus.io_input_output = io_io_q;
    assign bus.io_data_address = io_da_q;
    assign bus.io_clk_e        = clk_e_q;
    assign bus.io_clk_s        = clk_s_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.rdata           = rdata_q;
`ifdef IO_SEQ_TIMEOUT_EN
    assign bus.timeout_err     = terr_q;
`else
    assign bus.timeout_err     = 1'b0;
`endif

endmodule

// File: tb/tb_io_bus_sequencer.sv
// Self-checking bench for io_bus_sequencer: directed scenarios plus randomized back-to-back
// transfers, each checked cycle by cycle against a phase-duration reference model.
module tb_io_bus_sequencer;

    localparam int S   = 1;
    localparam int T   = 2;
    localparam int TMO = 4;

    logic clk = 1'b0;
    logic reset_n;

    io_bus_sequencer_if sif ();

    io_bus_sequencer #(
        .SETUP_CYC  (S),
        .STROBE_CYC (T),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (sif.slave)
    );

    always #5 clk = ~clk;

    // Packed view: {bus_out, io_input_output, io_data_address, clk_e, clk_s, busy, done, terr, rdata}
    logic [22:0] exp_v [64];
    logic [22:0] obs [64];
    bit          ack_plan [64];
    logic [7:0]  bin_plan [64];
    bit          start_pulse [64];
    logic [7:0]  exp_rdata;
    int          n_vec = 0;
    int          n_err = 0;

    function automatic logic [22:0] pack_obs();
        return {sif.bus_out, sif.io_input_output, sif.io_data_address, sif.io_clk_e,
                sif.io_clk_s, sif.busy, sif.done, sif.timeout_err, sif.rdata};
    endfunction

    task automatic init_plan(input bit ack_def);
        for (int i = 0; i < 64; i++) begin
            ack_plan[i]    = (i >= 40) ? 1'b1 : ack_def;
            bin_plan[i]    = 8'($urandom);
            start_pulse[i] = 1'b0;
        end
    endtask

    // Reference: address phase S+T cycles, data setup S cycles, data strobe until the first
    // cycle with ack once T strobe cycles have elapsed (or the timeout), then one done cycle.
    task automatic model(input bit rw, input logic [7:0] addr, input logic [7:0] wd,
                         output int e);
        int ds;
        bit tmo;
        logic [7:0] bo;
        bit iio, ida, ce, cs, bsy, dn, te;
        logic [7:0] rd;
        ds  = 2 * S + T + 1;
        e   = 41;
        tmo = 1'b0;
        for (int c = ds; c < 41; c++) begin
            if (c - ds + 1 >= T && ack_plan[c]) begin
                e = c;
                break;
            end
`ifdef IO_SEQ_TIMEOUT_EN
            if (c - ds + 1 == TMO) begin
                e   = c;
                tmo = 1'b1;
                break;
            end
`endif
        end
        for (int c = 1; c <= e + 2; c++) begin
            bo = 8'd0; iio = 0; ida = 0; ce = 0; cs = 0; bsy = 0; dn = 0;
            if (c <= S + T) begin
                bo = addr; iio = 1; ida = 1; bsy = 1; cs = (c > S);
            end else if (c <= e) begin
                bo = rw ? wd : 8'd0; iio = rw; bsy = 1;
                if (c > 2 * S + T) begin
                    cs = rw; ce = !rw;
                end
            end else if (c == e + 1) begin
                dn = 1;
            end
            te = (c > e) ? tmo : 1'b0;
            rd = (c > e && !rw && !tmo) ? bin_plan[e] : exp_rdata;
            exp_v[c] = {bo, iio, ida, ce, cs, bsy, dn, te, rd};
        end
        if (!rw && !tmo) exp_rdata = bin_plan[e];
    endtask

    // Entered and left at a negedge; request is accepted at the next posedge (edge 0).
    task automatic run_xfer(input bit rw, input logic [7:0] addr, input logic [7:0] wd,
                            input int ncyc);
        sif.start = 1'b1; sif.rd_wr = rw; sif.port_addr = addr; sif.wdata = wd;
        sif.ack = ack_plan[0]; sif.bus_in = bin_plan[0];
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            sif.start     = start_pulse[c];
            sif.rd_wr     = 1'($urandom);
            sif.port_addr = 8'($urandom);
            sif.wdata     = 8'($urandom);
            sif.ack       = ack_plan[c];
            sif.bus_in    = bin_plan[c];
            @(negedge clk);
            obs[c] = pack_obs();
        end
        sif.start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; sif.start = 1'b1; sif.rd_wr = 1'b1; sif.port_addr = 8'hFF;
        sif.wdata = 8'hFF; sif.ack = 1'b1; sif.bus_in = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); @(negedge clk);
            n_vec++;
            if (pack_obs() !== 23'd0) begin
                n_err++;
                $display("FAIL reset edge %0d: got %h expected 0", i, pack_obs());
            end
        end
        sif.start = 1'b0;
        reset_n   = 1'b1;
        @(posedge clk); @(negedge clk);
        n_vec++;
        if (pack_obs() !== 23'd0) begin
            n_err++;
            $display("FAIL reset idle: got %h expected 0", pack_obs());
        end
        exp_rdata = 8'd0;
    endtask

    task automatic test_write();
        int e;
        init_plan(1'b1);
        model(1'b1, 8'h3C, 8'hA5, e);
        run_xfer(1'b1, 8'h3C, 8'hA5, e + 2);
        for (int c = 1; c <= e + 2; c++) begin
            n_vec++;
            if (obs[c] !== exp_v[c]) begin
                n_err++;
                $display("FAIL write cycle %0d: got %h expected %h", c, obs[c], exp_v[c]);
            end
        end
    endtask

    task automatic test_read_stall();
        int e;
        init_plan(1'b0);
        for (int c = 9; c < 64; c++) ack_plan[c] = 1'b1;
        bin_plan[9] = 8'h5E;
        model(1'b0, 8'h10, 8'h00, e);
        run_xfer(1'b0, 8'h10, 8'h00, e + 2);
        for (int c = 1; c <= e + 2; c++) begin
            n_vec++;
            if (obs[c] !== exp_v[c]) begin
                n_err++;
                $display("FAIL read_stall cycle %0d: got %h expected %h", c, obs[c], exp_v[c]);
            end
        end
    endtask

    task automatic test_contention();
        int e;
        init_plan(1'b1);
        start_pulse[3] = 1'b1;
        start_pulse[7] = 1'b1;
        model(1'b1, 8'h42, 8'h99, e);
        run_xfer(1'b1, 8'h42, 8'h99, e + 2);
        for (int c = 1; c <= e + 2; c++) begin
            n_vec++;
            if (obs[c] !== exp_v[c]) begin
                n_err++;
                $display("FAIL contention cycle %0d: got %h expected %h", c, obs[c], exp_v[c]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int e;
        init_plan(1'b0);
        model(1'b0, 8'h77, 8'h00, e);
        exp_v[6]  = 23'd0;
        exp_v[7]  = 23'd0;
        exp_rdata = 8'd0;
        sif.start = 1'b1; sif.rd_wr = 1'b0; sif.port_addr = 8'h77; sif.wdata = 8'h00;
        sif.ack = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1;
            sif.start  = 1'b0;
            sif.bus_in = bin_plan[c];
            if (c == 5) reset_n = 1'b0;
            @(negedge clk);
            obs[c] = pack_obs();
        end
        reset_n = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            n_vec++;
            if (obs[c] !== exp_v[c]) begin
                n_err++;
                $display("FAIL reset_mid cycle %0d: got %h expected %h", c, obs[c], exp_v[c]);
            end
        end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_random_back_to_back();
        int e;
        bit rw;
        logic [7:0] addr, wd;
        for (int n = 0; n < 25; n++) begin
            init_plan(1'b0);
            for (int c = 0; c < 20; c++) ack_plan[c] = ($urandom_range(0, 2) == 0);
            for (int c = 20; c < 64; c++) ack_plan[c] = 1'b1;
            rw   = 1'($urandom);
            addr = 8'($urandom);
            wd   = 8'($urandom);
            model(rw, addr, wd, e);
            for (int c = 1; c <= e + 1; c++) start_pulse[c] = ($urandom_range(0, 3) == 0);
            run_xfer(rw, addr, wd, e + 2);
            for (int c = 1; c <= e + 2; c++) begin
                n_vec++;
                if (obs[c] !== exp_v[c]) begin
                    n_err++;
                    $display("FAIL random xfer %0d cycle %0d: got %h expected %h",
                             n, c, obs[c], exp_v[c]);
                end
            end
        end
    endtask

`ifdef IO_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int e;
        init_plan(1'b0);
        model(1'b0, 8'h21, 8'h00, e);
        run_xfer(1'b0, 8'h21, 8'h00, e + 2);
        for (int c = 1; c <= e + 2; c++) begin
            n_vec++;
            if (obs[c] !== exp_v[c]) begin
                n_err++;
                $display("FAIL timeout cycle %0d: got %h expected %h", c, obs[c], exp_v[c]);
            end
        end
        init_plan(1'b1);
        model(1'b1, 8'h22, 8'h33, e);
        run_xfer(1'b1, 8'h22, 8'h33, e + 2);
        for (int c = 1; c <= e + 2; c++) begin
            n_vec++;
            if (obs[c] !== exp_v[c]) begin
                n_err++;
                $display("FAIL timeout_clear cycle %0d: got %h expected %h", c, obs[c], exp_v[c]);
            end
        end
    endtask
`endif

    initial begin
        reset_n = 1'b0;
        sif.start = 1'b0; sif.rd_wr = 1'b0; sif.port_addr = 8'd0; sif.wdata = 8'd0;
        sif.ack = 1'b0; sif.bus_in = 8'd0;
        exp_rdata = 8'd0;
        test_reset();
        test_write();
        test_read_stall();
        test_contention();
        test_reset_mid();
        test_random_back_to_back();
`ifdef IO_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog");
    end

endmodule
